// File: rtl/hdb3_pkg.sv
// Shared HDB3 constants and symbol classification, common to encoder and decoder.
package hdb3_pkg;

    localparam int unsigned DLY_DEPTH     = 4;
    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned FILL_W        = $clog2(DLY_DEPTH + 1);

    typedef struct packed {
        logic illegal;
        logic mark;
        logic pol;
    } sym_t;

    // Both rails high is illegal and decodes as a space (mark = p ^ n = 0).
    function automatic sym_t classify(input logic p, input logic n);
        sym_t s;
        s.illegal = p & n;
        s.mark    = p ^ n;
        s.pol     = p;
        return s;
    endfunction

endpackage

// File: rtl/hdb3_if.sv
// Dual-rail symbol input and decoded-output bundle of the HDB3 decoder.
interface hdb3_if #(
    parameter int unsigned CNT_W = hdb3_pkg::CNT_W_DEFAULT
) ();

    logic             bit_en;
    logic             hdb3_p;
    logic             hdb3_n;
    logic             dec_data;
    logic             dec_valid;
    logic             sym_err;
    logic             viol_err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output bit_en, hdb3_p, hdb3_n,
        input  dec_data, dec_valid, sym_err, viol_err, err_cnt
    );

    modport slave (
        input  bit_en, hdb3_p, hdb3_n,
        output dec_data, dec_valid, sym_err, viol_err, err_cnt
    );

endinterface

// File: rtl/hdb3_err_counter.sv
// Saturating up-counter with a single-step increment enable.
module hdb3_err_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 to NRZ decoder: 4-symbol delay line with B00V/000V removal, symbol and
// violation-polarity error detection, and a saturating error counter.
module hdb3_decoder
    import hdb3_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic   sys_clk,
    input  logic   rst,
    hdb3_if.slave  bus
);

    logic [DLY_DEPTH-1:0] r_s;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_last_pol;
    logic                 r_have_mark;
    logic                 r_last_vpol;
    logic                 r_have_v;
    logic                 r_dec_data;
    logic                 r_dec_valid;
    logic                 r_sym_err;
    logic                 r_viol_err;

    sym_t                 w_sym;
    logic                 w_is_v;
    logic                 w_vpol_bad;
    logic                 w_full;
    logic                 w_inc;
    logic [DLY_DEPTH-1:0] w_s_next;

    always_comb begin
        w_sym      = classify(bus.hdb3_p, bus.hdb3_n);
        w_is_v     = w_sym.mark && r_have_mark && (w_sym.pol == r_last_pol);
        w_vpol_bad = w_is_v && r_have_v && (w_sym.pol == r_last_vpol);
        w_full     = (r_fill == FILL_W'(DLY_DEPTH));
        w_inc      = bus.bit_en && (w_sym.illegal || w_vpol_bad);
        // A V zeroes itself and the B three symbols back, which is about to move into s[3].
        if (w_is_v) begin
            w_s_next = {1'b0, r_s[DLY_DEPTH-3:0], 1'b0};
        end else begin
            w_s_next = {r_s[DLY_DEPTH-2:0], w_sym.mark};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_s         <= '0;
            r_fill      <= '0;
            r_last_pol  <= 1'b0;
            r_have_mark <= 1'b0;
            r_last_vpol <= 1'b0;
            r_have_v    <= 1'b0;
            r_dec_data  <= 1'b0;
            r_dec_valid <= 1'b0;
            r_sym_err   <= 1'b0;
            r_viol_err  <= 1'b0;
        end else begin
            r_dec_valid <= 1'b0;
            r_sym_err   <= 1'b0;
            r_viol_err  <= 1'b0;
            if (bus.bit_en) begin
                r_s        <= w_s_next;
                r_sym_err  <= w_sym.illegal;
                r_viol_err <= w_vpol_bad;
                if (!w_full) begin
                    r_fill <= r_fill + FILL_W'(1);
                end else begin
                    r_dec_data  <= r_s[DLY_DEPTH-1];
                    r_dec_valid <= 1'b1;
                end
                if (w_sym.mark) begin
                    r_last_pol  <= w_sym.pol;
                    r_have_mark <= 1'b1;
                end
                if (w_is_v) begin
                    r_last_vpol <= w_sym.pol;
                    r_have_v    <= 1'b1;
                end
            end
        end
    end

    hdb3_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .i_clk (sys_clk),
        .i_rst (rst),
        .i_inc (w_inc),
        .o_cnt (bus.err_cnt)
    );

    assign bus.dec_data  = r_dec_data;
    assign bus.dec_valid = r_dec_valid;
    assign bus.sym_err   = r_sym_err;
    assign bus.viol_err  = r_viol_err;

endmodule
